// File: rtl/mul_pkg.sv
// Shared helpers for the pipelined array multiplier: stage count and Baugh-Wooley constant.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mul_pkg;

  localparam int BW_MAX = 128;

  function automatic int stages_f(input int n, input int r);
    return (n + r - 1) / r;
  endfunction

  // 2^N + 2^(2N-1): folds the inverted-MSB corrections back into an exact signed product
  function automatic logic [BW_MAX-1:0] bw_const_f(input int n);
    logic [BW_MAX-1:0] c;
    c = '0;
    c[n] = 1'b1;
    c[2*n-1] = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/mul_row_group.sv
// Adds partial-product rows BASE..BASE+R-1 (clipped at N) to a running 2N-bit sum.
// Latency: combinational, zero cycles.
// Backpressure: none; the enclosing pipeline stage decides when the result is captured.
module mul_row_group
  import mul_pkg::*;
#(
  parameter int N    = 10,
  parameter int R    = 1,
  parameter int BASE = 0
) (
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  input  logic           tc,
  input  logic [2*N-1:0] sum_i,
  output logic [2*N-1:0] sum_o
);

  localparam int LAST = (BASE + R < N) ? (BASE + R) : N;
  localparam logic [BW_MAX-1:0] BW_FULL = bw_const_f(N);

  logic [N-1:0] row;

  always_comb begin
    row   = '0;
    sum_o = sum_i;
    if (BASE == 0 && tc) begin
      sum_o = sum_o + BW_FULL[2*N-1:0];
    end
    for (int i = BASE; i < LAST; i++) begin
      row = x & {N{y[i]}};
      // Baugh-Wooley: the top row is negated except its MSB term, other rows invert their MSB term
      if (tc) begin
        if (i == N - 1) begin
          row[N-2:0] = ~row[N-2:0];
        end else begin
          row[N-1] = ~row[N-1];
        end
      end
      sum_o = sum_o + ({{N{1'b0}}, row} << i);
    end
  end

  // only this group's multiplier bits drive a row
  logic unused_y;
  assign unused_y = ^y;

endmodule

// File: rtl/mul_pipe_array.sv
// Pipelined shift-and-add array multiplier, signed/unsigned per transaction.
// Latency: STAGES = ceil(N/ROWS_PER_STAGE) cycles, one product per cycle.
// Backpressure: global stall; every stage holds while out_valid && !out_ready.
module mul_pipe_array
  import mul_pkg::*;
#(
  parameter int N              = 10,
  parameter int ROWS_PER_STAGE = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  input  logic           tc,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] z
);

  localparam int STAGES = stages_f(N, ROWS_PER_STAGE);

  // stage payload; its width follows N so it is declared alongside the pipeline
  typedef struct packed {
    logic           tc;
    logic [N-1:0]   x;
    logic [N-1:0]   y;
    logic [2*N-1:0] sum;
  } payload_t;

  logic adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    payload_t       src;
    logic           src_vld;
    logic [2*N-1:0] grp_sum;
    payload_t       stg_d;
    payload_t       stg_q;
    logic           vld_d;
    logic           vld_q;

    if (k == 0) begin : g_head
      assign src     = '{tc: tc, x: x, y: y, sum: '0};
      assign src_vld = in_valid;
    end else begin : g_body
      assign src     = g_stage[k-1].stg_q;
      assign src_vld = g_stage[k-1].vld_q;
    end

    mul_row_group #(
      .N    (N),
      .R    (ROWS_PER_STAGE),
      .BASE (k * ROWS_PER_STAGE)
    ) u_rows (
      .x     (src.x),
      .y     (src.y),
      .tc    (src.tc),
      .sum_i (src.sum),
      .sum_o (grp_sum)
    );

    always_comb begin
      vld_d = vld_q;
      stg_d = stg_q;
      if (adv) begin
        vld_d = src_vld;
        stg_d = '{tc: src.tc, x: src.x, y: src.y, sum: grp_sum};
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
      end else begin
        vld_q <= vld_d;
      end
    end

    always_ff @(posedge clk) begin
      stg_q <= stg_d;
    end
  end

  assign out_valid = g_stage[STAGES-1].vld_q;
  assign z         = g_stage[STAGES-1].stg_q.sum;

  // operands ride to the last stage but only its sum leaves the block
  logic unused_tail;
  assign unused_tail = ^{g_stage[STAGES-1].stg_q.tc, g_stage[STAGES-1].stg_q.x,
                         g_stage[STAGES-1].stg_q.y};

endmodule

// File: tb/tb_mul_pipe_array.sv
// Self-checking bench: directed vectors, throughput, stall, reset, and a parameter sweep.
// Latency: n/a. Backpressure: exercised via out_ready.
module tb_mul_pipe_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // exact product from integer arithmetic, truncated to 2n bits
  function automatic longint ref_mul(input int n, input logic [9:0] a, input logic [9:0] b,
                                     input logic t);
    longint av, bv, m;
    m  = (longint'(1) << n) - 1;
    av = longint'(a) & m;
    bv = longint'(b) & m;
    if (t && a[n-1]) av = av - (longint'(1) << n);
    if (t && b[n-1]) bv = bv - (longint'(1) << n);
    return (av * bv) & ((longint'(1) << (2 * n)) - 1);
  endfunction

  // ---------------- default configuration N=8, R=2 ----------------
  logic        rst_n;
  logic        iv8, ir8, tc8, ov8, or8;
  logic [7:0]  x8, y8;
  logic [15:0] z8;

  mul_pipe_array #(.N(8), .ROWS_PER_STAGE(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .x(x8), .y(y8), .tc(tc8),
    .out_valid(ov8), .out_ready(or8), .z(z8)
  );

  // ---------------- sweep configurations ----------------
  logic        rst_sw_n;
  logic [9:0]  xs [4];
  logic [9:0]  ys [4];
  logic        tcs [4];
  logic        ivs [4];
  logic        ir_s [4];
  logic        ov_s [4];
  logic        ors;
  logic [19:0] z_s0, z_s1, z_s2;
  logic [3:0]  z_s3;

  mul_pipe_array #(.N(10), .ROWS_PER_STAGE(1)) u_sw0 (
    .clk(clk), .rst_n(rst_sw_n), .in_valid(ivs[0]), .in_ready(ir_s[0]), .x(xs[0]), .y(ys[0]),
    .tc(tcs[0]), .out_valid(ov_s[0]), .out_ready(ors), .z(z_s0));
  mul_pipe_array #(.N(10), .ROWS_PER_STAGE(3)) u_sw1 (
    .clk(clk), .rst_n(rst_sw_n), .in_valid(ivs[1]), .in_ready(ir_s[1]), .x(xs[1]), .y(ys[1]),
    .tc(tcs[1]), .out_valid(ov_s[1]), .out_ready(ors), .z(z_s1));
  mul_pipe_array #(.N(10), .ROWS_PER_STAGE(10)) u_sw2 (
    .clk(clk), .rst_n(rst_sw_n), .in_valid(ivs[2]), .in_ready(ir_s[2]), .x(xs[2]), .y(ys[2]),
    .tc(tcs[2]), .out_valid(ov_s[2]), .out_ready(ors), .z(z_s2));
  mul_pipe_array #(.N(2), .ROWS_PER_STAGE(1)) u_sw3 (
    .clk(clk), .rst_n(rst_sw_n), .in_valid(ivs[3]), .in_ready(ir_s[3]), .x(xs[3][1:0]),
    .y(ys[3][1:0]), .tc(tcs[3]), .out_valid(ov_s[3]), .out_ready(ors), .z(z_s3));

  function automatic longint zget(input int d);
    case (d)
      0:       return longint'(z_s0);
      1:       return longint'(z_s1);
      2:       return longint'(z_s2);
      default: return longint'(z_s3);
    endcase
  endfunction

  // ---------------- scoreboard for the default DUT ----------------
  longint q8 [$];
  int     n_out8 = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q8.delete();
    end else begin
      if (ov8 && or8) begin
        if (q8.size() == 0) begin
          chk("sb_unexpected_out", longint'(z8), -1);
        end else begin
          chk("sb_z", longint'(z8), q8.pop_front());
        end
        n_out8++;
      end
      if (iv8 && ir8) q8.push_back(ref_mul(8, {2'b0, x8}, {2'b0, y8}, tc8));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic        tc;
    logic [15:0] z;
  } vec_t;

  typedef struct {
    longint z;
    int     e;
  } exp_t;

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    @(posedge clk); #1;
    x8 = v.x; y8 = v.y; tc8 = v.tc; iv8 = 1'b1; or8 = 1'b1;
    @(posedge clk); lat = 1; #1;
    iv8 = 1'b0;
    @(negedge clk);
    while (!ov8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("vec%0d_z", idx), longint'(z8), longint'(v.z));
    chk($sformatf("vec%0d_latency", idx), lat, 4);
  endtask

  initial begin
    vec_t   vt [8];
    int     first, last, cnt, w, n0, ec;
    longint held;
    int     sn  [4];
    int     sst [4];
    int     sent [4];
    int     got  [4];
    exp_t   sq [4][$];
    exp_t   e;
    logic [9:0] msk;
    bit     done;

    vt[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    vt[1] = '{8'h80, 8'h80, 1'b1, 16'h4000};
    vt[2] = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
    vt[3] = '{8'h80, 8'h80, 1'b0, 16'h4000};
    vt[4] = '{8'hFF, 8'h01, 1'b0, 16'h00FF};
    vt[5] = '{8'h7F, 8'h80, 1'b1, 16'hC080};
    vt[6] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
    vt[7] = '{8'h00, 8'hFF, 1'b1, 16'h0000};
    sn  = '{10, 10, 10, 2};
    sst = '{10, 4, 1, 2};

    rst_n = 1'b0; rst_sw_n = 1'b0;
    iv8 = 1'b0; or8 = 1'b0; x8 = '0; y8 = '0; tc8 = 1'b0; ors = 1'b1;
    for (int d = 0; d < 4; d++) begin
      xs[d] = '0; ys[d] = '0; tcs[d] = 1'b0; ivs[d] = 1'b0;
    end

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", ov8, 0);
    chk("reset_in_ready", ir8, 1);
    for (int d = 0; d < 4; d++) chk($sformatf("reset_sweep%0d_out_valid", d), ov_s[d], 0);
    rst_n = 1'b1; rst_sw_n = 1'b1;

    // directed vectors
    for (int i = 0; i < 8; i++) run_vec(vt[i], i);

    // back-to-back throughput with alternating mode
    repeat (4) @(posedge clk);
    first = -1; last = -1; cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (c < 16) begin
        x8 = 8'($urandom); y8 = 8'($urandom); tc8 = 1'(c % 2); iv8 = 1'b1;
      end else begin
        iv8 = 1'b0;
      end
      @(negedge clk);
      if (ov8) begin
        if (first < 0) first = c;
        last = c;
        cnt++;
      end
    end
    chk("b2b_count", cnt, 16);
    chk("b2b_contiguous", last - first, 15);

    // backpressure
    n0 = n_out8;
    @(posedge clk); #1;
    or8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      x8 = 8'($urandom); y8 = 8'($urandom); tc8 = 1'($urandom_range(1, 0)); iv8 = 1'b1;
      @(posedge clk); #1;
    end
    iv8 = 1'b0;
    w = 0;
    while (!ov8 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("bp_result_arrives", ov8, 1);
    held = longint'(z8);
    chk("bp_held_vs_model", held, (q8.size() > 0) ? q8[0] : -1);
    x8 = 8'($urandom); y8 = 8'($urandom); tc8 = 1'($urandom_range(1, 0)); iv8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_z_stable", longint'(z8), held);
      chk("bp_out_valid_held", ov8, 1);
      chk("bp_in_ready_low", ir8, 0);
    end
    @(posedge clk); #1;
    or8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("bp_output_count", n_out8 - n0, 4);
    chk("bp_drained", q8.size(), 0);

    // reset mid-flight
    for (int i = 0; i < 3; i++) begin
      x8 = 8'($urandom); y8 = 8'($urandom); tc8 = 1'($urandom_range(1, 0)); iv8 = 1'b1;
      @(posedge clk); #1;
    end
    iv8 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; or8 = 1'b0;
    #1;
    chk("rst_mid_out_valid", ov8, 0);
    chk("rst_mid_in_ready", ir8, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; or8 = 1'b1;
    n0 = n_out8;
    repeat (12) @(posedge clk);
    #1;
    chk("rst_no_output_after_release", n_out8 - n0, 0);

    // parameter sweep: random issue, out_ready held high
    ec = 0;
    for (int d = 0; d < 4; d++) begin
      sent[d] = 0; got[d] = 0;
    end
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(posedge clk);
      ec++;
      #1;
      for (int d = 0; d < 4; d++) begin
        msk = 10'((1 << sn[d]) - 1);
        if (sent[d] < 2000 && $urandom_range(3, 0) != 0) begin
          xs[d] = 10'($urandom) & msk; ys[d] = 10'($urandom) & msk;
          tcs[d] = 1'($urandom_range(1, 0)); ivs[d] = 1'b1;
        end else begin
          ivs[d] = 1'b0;
        end
      end
      @(negedge clk);
      done = 1'b1;
      for (int d = 0; d < 4; d++) begin
        if (ov_s[d]) begin
          if (sq[d].size() == 0) begin
            chk($sformatf("sweep%0d_unexpected_out", d), zget(d), -1);
          end else begin
            e = sq[d].pop_front();
            chk($sformatf("sweep%0d_z", d), zget(d), e.z);
            chk($sformatf("sweep%0d_latency", d), ec - e.e + 1, sst[d]);
          end
          got[d]++;
        end
        if (ivs[d] && ir_s[d]) begin
          sq[d].push_back('{ref_mul(sn[d], xs[d], ys[d], tcs[d]), ec + 1});
          sent[d]++;
        end
        if (got[d] < 2000) done = 1'b0;
      end
      if (done) break;
    end
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("sweep%0d_count", d), got[d], 2000);
      chk($sformatf("sweep%0d_drained", d), sq[d].size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
